// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared types and default sizing for the RAM program loader.
//  Revision    : 1.0  initial release
// ============================================================================
package loader_pkg;

    // Default RAM geometry: 16 bytes addressed by 4 bits
    localparam int RAM_BYTES_DEF = 16;
    localparam int ADDR_W_DEF    = 4;

    // Loader session states, explicitly encoded
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_STB = 3'd1,
        WRITE    = 3'd2,
        WAIT_REL = 3'd3,
        DONE     = 3'd4
    } loader_state_e;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/loader_sync.sv
`default_nettype none
// ============================================================================
//  Module      : loader_sync
//  Description : Multi-stage flip-flop synchronizer for one asynchronous
//                host level. Output lags the input by SYNC_STAGES clocks.
//  Revision    : 1.0  initial release
// ============================================================================
module loader_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the asynchronous level through the synchronizer chain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = r_sync[SYNC_STAGES-1];

endmodule : loader_sync
`default_nettype wire

// File: rtl/ram_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ram_program_loader
//  Description : Host-side writer for the program RAM. Captures bytes from
//                the pins via a four-phase strobe/ack handshake, writes them
//                sequentially from address 0 and holds the CPU in clear
//                while the session is active.
//  Options     : LOADER_CHECKSUM_EN - when defined, 'checksum' carries the
//                modulo-256 sum of the bytes written this session; when
//                undefined the port is tied to 8'h00 and no adder exists.
//  Revision    : 1.0  initial release
// ============================================================================
module ram_program_loader
    import loader_pkg::*;
#(
    parameter int RAM_BYTES   = RAM_BYTES_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              host_stb,
    input  logic [7:0]        host_data,
    output logic              host_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_we_n,
    output logic              cpu_hold,
    output logic              done,
    output logic [ADDR_W:0]   byte_count,
    output logic [7:0]        checksum
);

    localparam logic [ADDR_W:0]   c_full      = (ADDR_W+1)'(RAM_BYTES);
    localparam logic [ADDR_W:0]   c_count_one = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);

    logic              w_ld_s;
    logic              w_stb_s;

    loader_state_e     r_state;
    loader_state_e     w_state_next;

    logic              w_clear;
    logic              w_capture;
    logic              w_commit;

    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data;
    logic [ADDR_W:0]   r_byte_count;

    logic              r_host_ack;
    logic              r_ram_we_n;
    logic              r_cpu_hold;
    logic              r_done;

    loader_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_ld (
        .clk      (clk),
        .rst      (rst),
        .async_in (load_en),
        .sync_out (w_ld_s)
    );

    loader_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_stb (
        .clk      (clk),
        .rst      (rst),
        .async_in (host_stb),
        .sync_out (w_stb_s)
    );

    // Next-state decode plus one-cycle datapath strobes
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_capture    = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ld_s) begin
                    w_state_next = WAIT_STB;
                    w_clear      = 1'b1;
                end
            end
            WAIT_STB: begin
                // A strobe already in flight wins over the end of session
                if (w_stb_s) begin
                    w_state_next = WRITE;
                    w_capture    = 1'b1;
                end else if (!w_ld_s) begin
                    w_state_next = DONE;
                end
            end
            WRITE: begin
                w_state_next = WAIT_REL;
                w_commit     = 1'b1;
            end
            WAIT_REL: begin
                // byte_count already reflects the byte just written
                if (!w_stb_s) begin
                    if ((r_byte_count == c_full) || !w_ld_s) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = WAIT_STB;
                    end
                end
            end
            DONE: begin
                if (!w_ld_s) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register with glitch-free registered outputs decoded from next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_host_ack <= 1'b0;
            r_ram_we_n <= 1'b1;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_host_ack <= (w_state_next == WAIT_REL);
            r_ram_we_n <= (w_state_next != WRITE);
            r_cpu_hold <= (w_state_next == WAIT_STB) ||
                          (w_state_next == WRITE)    ||
                          (w_state_next == WAIT_REL);
            r_done     <= (w_state_next == DONE);
        end
    end

    // Address counter, data capture and saturating byte counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_data       <= 8'h00;
            r_byte_count <= '0;
        end else if (w_clear) begin
            r_addr       <= '0;
            r_byte_count <= '0;
        end else if (w_capture) begin
            // host_data is held stable by the host until ack, so direct sampling is safe
            r_data <= host_data;
        end else if (w_commit) begin
            r_addr <= r_addr + c_addr_one;
            if (r_byte_count != c_full) begin
                r_byte_count <= r_byte_count + c_count_one;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_checksum;

    // Running modulo-256 sum of the bytes committed this session
    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= 8'h00;
        end else if (w_clear) begin
            r_checksum <= 8'h00;
        end else if (w_commit) begin
            r_checksum <= r_checksum + r_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 8'h00;
`endif

    assign host_ack   = r_host_ack;
    assign ram_addr   = r_addr;
    assign ram_data   = r_data;
    assign ram_we_n   = r_ram_we_n;
    assign cpu_hold   = r_cpu_hold;
    assign done       = r_done;
    assign byte_count = r_byte_count;

endmodule : ram_program_loader
`default_nettype wire

// File: tb/tb_ram_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_program_loader
//  Description : Self-checking bench for ram_program_loader. A host model
//                drives randomized sessions; expected RAM writes, counts and
//                checksums come from a simple list-of-bytes reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_program_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_en;
    logic       host_stb;
    logic [7:0] host_data;
    logic       host_ack;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we_n;
    logic       cpu_hold;
    logic       done;
    logic [4:0] byte_count;
    logic [7:0] checksum;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] obs_addr[$];
    logic [7:0] obs_data[$];
    logic       prev_we_n = 1'b1;

    always #5 clk = ~clk;

    ram_program_loader dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .host_stb   (host_stb),
        .host_data  (host_data),
        .host_ack   (host_ack),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_we_n   (ram_we_n),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .byte_count (byte_count),
        .checksum   (checksum)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_checksum(input int sum);
`ifdef LOADER_CHECKSUM_EN
        return 32'(sum % 256);
`else
        return 32'(sum * 0);
`endif
    endfunction

    // Write monitor: records every RAM write and checks pulse shape
    always @(negedge clk) begin
        if (ram_we_n === 1'b0) begin
            check_value("we_n_single_cycle", 32'(prev_we_n), 32'd1);
            check_value("hold_during_write", 32'(cpu_hold), 32'd1);
            obs_addr.push_back(ram_addr);
            obs_data.push_back(ram_data);
        end
`ifndef LOADER_CHECKSUM_EN
        if (ram_we_n === 1'b0) check_value("checksum_tied_zero", 32'(checksum), 32'd0);
`endif
        prev_we_n = ram_we_n;
    end

    task automatic wait_ack(input logic val);
        int n = 0;
        while (host_ack !== val && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_value("ack_wait", 32'(host_ack), 32'(val));
    endtask

    task automatic wait_done(input logic val);
        int n = 0;
        while (done !== val && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_value("done_wait", 32'(done), 32'(val));
    endtask

    task automatic wait_hold(input logic val);
        int n = 0;
        while (cpu_hold !== val && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_value("hold_wait", 32'(cpu_hold), 32'(val));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_ack"},   32'(host_ack),   32'd0);
        check_value({tag, "_we_n"},  32'(ram_we_n),   32'd1);
        check_value({tag, "_addr"},  32'(ram_addr),   32'd0);
        check_value({tag, "_data"},  32'(ram_data),   32'd0);
        check_value({tag, "_hold"},  32'(cpu_hold),   32'd0);
        check_value({tag, "_done"},  32'(done),       32'd0);
        check_value({tag, "_count"}, 32'(byte_count), 32'd0);
        check_value({tag, "_cksum"}, 32'(checksum),   32'd0);
    endtask

    // One host session. data_mode: 0 random, 1 byte index, 2 constant 0xA5.
    // drop_last lowers load_en while the strobe of the last byte is high.
    task automatic run_session(input int nbytes, input int data_mode,
                               input int hold_cycles, input bit drop_last);
        logic [7:0] exp_data[$];
        logic [7:0] b;
        int         sum = 0;
        int         exp_cnt;

        obs_addr.delete();
        obs_data.delete();
        load_en = 1'b1;
        wait_hold(1'b1);

        for (int i = 0; i < nbytes; i++) begin
            case (data_mode)
                1:       b = 8'(i);
                2:       b = 8'hA5;
                default: b = 8'($urandom);
            endcase
            exp_data.push_back(b);
            sum += int'(b);
            host_data = b;
            host_stb  = 1'b1;
            if (drop_last && (i == nbytes - 1)) begin
                @(negedge clk);
                load_en = 1'b0;
            end
            wait_ack(1'b1);
            for (int h = 0; h < hold_cycles; h++) begin
                @(negedge clk);
                check_value("ack_held", 32'(host_ack), 32'd1);
            end
            host_stb  = 1'b0;
            host_data = 8'($urandom);
            wait_ack(1'b0);
        end

        if (nbytes < 16) load_en = 1'b0;
        wait_done(1'b1);

        exp_cnt = (nbytes > 16) ? 16 : nbytes;
        check_value("done_count", 32'(byte_count), 32'(exp_cnt));
        check_value("done_cksum", 32'(checksum), exp_checksum(sum));
        check_value("done_hold",  32'(cpu_hold), 32'd0);

        load_en = 1'b0;
        wait_done(1'b0);

        check_value("write_count", 32'(obs_addr.size()), 32'(exp_cnt));
        for (int i = 0; i < exp_cnt && i < obs_addr.size(); i++) begin
            check_value($sformatf("write_addr_%0d", i), 32'(obs_addr[i]), 32'(i % 16));
            check_value($sformatf("write_data_%0d", i), 32'(obs_data[i]), 32'(exp_data[i]));
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        load_en   = 1'b0;
        host_stb  = 1'b0;
        host_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte 0xA5
        run_session(1, 2, 0, 1'b0);

        // Full RAM, bytes 0x00..0x0F, load_en held: checksum 0x78
        run_session(16, 1, 0, 1'b0);

        // Early end: load_en drops during strobe of byte 3
        run_session(3, 0, 0, 1'b1);

        // Slow host: strobe held high for a long time
        run_session(1, 0, 20, 1'b0);

        // Randomized sessions
        for (int s = 0; s < 8; s++) begin
            run_session(int'($urandom_range(1, 16)), 0,
                        int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a handshake (WAIT_REL)
        obs_addr.delete();
        obs_data.delete();
        load_en = 1'b1;
        wait_hold(1'b1);
        host_data = 8'h3C;
        host_stb  = 1'b1;
        wait_ack(1'b1);
        rst      = 1'b1;
        load_en  = 1'b0;
        host_stb = 1'b0;
        obs_addr.delete();
        obs_data.delete();
        @(negedge clk);
        check_reset_outputs("midrst1");
        @(negedge clk);
        check_reset_outputs("midrst2");
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check_value("post_reset_writes", 32'(obs_addr.size()), 32'd0);
        check_value("post_reset_hold",   32'(cpu_hold), 32'd0);
        check_value("post_reset_done",   32'(done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ram_program_loader
`default_nettype wire

// File: doc/ram_program_loader.md
# ram_program_loader

Host-side writer for the 16-byte program RAM. It captures bytes presented on the chip pins through a four-phase strobe/ack handshake and writes them sequentially into RAM from address 0. While loading it holds the CPU core in clear; it releases the core when the RAM is full or the host ends the session. It is the write-side counterpart of the CPU's MAR/RAM read path and sits between the pin inputs and the RAM write port.

## Interface
Parameters:
- RAM_BYTES, 16, number of RAM locations; must be a power of two.
- ADDR_W, 4, address width; log2(RAM_BYTES).
- SYNC_STAGES, 2, flip-flop stages on the asynchronous host inputs; minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high. One clock; all state is reset on the clk edge where rst=1.
- load_en  in  1  host session request, asynchronous level.
- host_stb  in  1  host byte strobe, asynchronous level.
- host_data  in  8  host byte; stable from the host_stb rise until ack rises.
- host_ack  out  1  handshake acknowledge, registered.
- ram_addr  out  ADDR_W  RAM write address.
- ram_data  out  8  RAM write data.
- ram_we_n  out  1  RAM write strobe, active-low, one cycle per byte.
- cpu_hold  out  1  holds the CPU in clear while high.
- done  out  1  session finished.
- byte_count  out  ADDR_W+1  bytes written in the current session.
- checksum  out  8  running sum of the bytes written (see Configuration).

## Operation
- load_en and host_stb each pass through SYNC_STAGES flops. Their synchronized versions are ld_s and stb_s.
- State machine:
  - IDLE
    - cpu_hold=0, done=0.
    - ld_s=1 → WAIT_STB; clear addr, byte_count and checksum.
  - WAIT_STB
    - cpu_hold=1.
    - stb_s=1 → WRITE; capture host_data into the data register.
    - Otherwise ld_s=0 → DONE.
    - stb_s takes priority over ld_s.
  - WRITE
    - Lasts one cycle.
    - ram_we_n=0, ram_addr=addr, ram_data=captured byte.
    - → WAIT_REL.
  - WAIT_REL
    - host_ack=1.
    - On entry: addr increments modulo RAM_BYTES; byte_count and checksum update.
    - stb_s=0 → host_ack=0, then:
      - → DONE if byte_count==RAM_BYTES or ld_s=0;
      - → WAIT_STB otherwise.
  - DONE
    - done=1, cpu_hold=0.
    - ld_s=0 → IDLE.
- Deasserting load_en during WRITE or WAIT_REL does not abort the transfer. The current handshake completes first.
- Arithmetic:
  - addr wraps at RAM_BYTES.
  - byte_count saturates at RAM_BYTES and never wraps.
  - checksum is a sum modulo 256.

## Timing
- Reset values:
  - state=IDLE, host_ack=0, ram_we_n=1, ram_addr=0, ram_data=0x00.
  - cpu_hold=0, done=0, byte_count=0, checksum=0x00.
  - Synchronizer flops are cleared to 0.
- Host pin to ld_s/stb_s latency: SYNC_STAGES cycles.
- Let cycle N be the cycle in which stb_s is first seen high in WAIT_STB:
  - host_data is sampled at the end of cycle N.
  - ram_we_n is low in cycle N+1.
  - host_ack is high from cycle N+2.
- host_ack falls one cycle after stb_s is seen low.
- Minimum handshake: 4 + 2·SYNC_STAGES cycles per byte.
- cpu_hold rises one cycle after ld_s is seen in IDLE. It falls on the cycle the FSM enters DONE.
- ram_we_n is never low for two consecutive cycles. It is never low outside WRITE.
- Reset mid-operation: the FSM returns to IDLE on the next edge and any pending write is dropped. ram_we_n is 1 in the cycle after the rst edge.
- rst and stb_s high together: rst wins.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - checksum holds the modulo-256 sum of the bytes written in the current session.
  - It is cleared on the IDLE→WAIT_STB transition.
  - It is valid once done=1.
- LOADER_CHECKSUM_EN undefined:
  - The checksum port remains in the port list, tied to 8'h00.
  - No adder is generated.

## Structure
- Shared package loader_pkg contains:
  - the state enum (IDLE, WAIT_STB, WRITE, WAIT_REL, DONE);
  - the default constants RAM_BYTES_DEF=16 and ADDR_W_DEF=4.
- One sub-module, loader_sync: a SYNC_STAGES-deep synchronizer, instantiated once each for load_en and host_stb.
- All other logic (FSM, address counter, data register, checksum) lives in the top of this block.

## Test plan
- Reset: assert rst for 2 cycles during WAIT_REL.
  - Required: all outputs at their reset values; no ram_we_n pulse afterwards.
- Single byte:
  - Stimulus: load_en=1; handshake host_data=0xA5; then load_en=0.
  - Required:
    - exactly one ram_we_n pulse, with addr=0 and data=0xA5;
    - byte_count=1, done=1, cpu_hold falls;
    - checksum=0xA5 with LOADER_CHECKSUM_EN defined.
- Full RAM:
  - Stimulus: 16 handshakes with bytes 0x00..0x0F, load_en held high.
  - Required:
    - addresses 0..15 in order;
    - DONE after the 16th ack falls;
    - byte_count=16, checksum=0x78.
- Early end:
  - Stimulus: drop load_en while host_stb is high for byte 3.
  - Required: byte 3 is written at addr 2, the handshake completes, then DONE with byte_count=3.
- Slow host: hold host_stb high for 20 cycles.
  - Required: exactly one write; host_ack stays high until stb_s falls.
- Macro off: repeat the single-byte test with LOADER_CHECKSUM_EN undefined.
  - Required: checksum=0x00 at all times; write behaviour identical to the macro-on run.
